// File: rtl/point_referee_if.sv
// Bus between the point referee, the ball-motion logic and the score counter.
interface point_referee_if #(
    parameter int unsigned X_W = 10
);
    logic           frame_tick;
    logic           start;
    logic [X_W-1:0] ball_x;
    logic [3:0]     score_1;
    logic [3:0]     score_2;
    logic           p1_point;
    logic           p2_point;
    logic           ball_reset;
    logic           serve_dir;
    logic           game_over;
    logic           winner;

    // Environment side: drives frame timing, ball position and scores.
    modport master (
        output frame_tick, start, ball_x, score_1, score_2,
        input  p1_point, p2_point, ball_reset, serve_dir, game_over, winner
    );

    // Referee side.
    modport slave (
        input  frame_tick, start, ball_x, score_1, score_2,
        output p1_point, p2_point, ball_reset, serve_dir, game_over, winner
    );
endinterface

// File: rtl/point_referee.sv
// Point detection and serve sequencing for the Pong datapath.
// Watches ball_x once per frame, pulses the scoring player's point line,
// holds the ball for a serve delay and ends the game at the win threshold.
module point_referee #(
    parameter int unsigned X_W         = 10,
    parameter int unsigned LEFT_LIMIT  = 0,
    parameter int unsigned RIGHT_LIMIT = 632,
    parameter int unsigned SERVE_DELAY = 60,
    parameter int unsigned WIN_SCORE   = 9
) (
    input  logic             clk,
    input  logic             rst,
    point_referee_if.slave   bus
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SCORE_W = 4;

    localparam logic [X_W-1:0]     LP_LEFT  = X_W'(LEFT_LIMIT);
    localparam logic [X_W-1:0]     LP_RIGHT = X_W'(RIGHT_LIMIT);
    localparam logic [CNT_W-1:0]   LP_DELAY = CNT_W'(SERVE_DELAY);
    localparam logic [SCORE_W-1:0] LP_WIN   = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_WAIT_START = 3'd0,
        ST_PLAY       = 3'd1,
        ST_SCORED     = 3'd2,
        ST_SERVE      = 3'd3,
        ST_OVER       = 3'd4
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic               r_p1_point;
    logic               r_p2_point;
    logic               r_ball_reset;
    logic               r_serve_dir;
    logic               r_game_over;
    logic               r_winner;

    logic               w_p1_point_nxt;
    logic               w_p2_point_nxt;
    logic               w_ball_reset_nxt;
    logic               w_serve_dir_nxt;
    logic               w_game_over_nxt;
    logic               w_winner_nxt;

    logic               w_left_out;
    logic               w_right_out;
    logic               w_p1_wins;
    logic               w_p2_wins;

    // Edge and win-threshold comparisons used by the state logic.
    always_comb begin
        w_left_out  = (bus.ball_x <= LP_LEFT);
        w_right_out = (bus.ball_x >= LP_RIGHT);
        w_p1_wins   = (bus.score_1 >= LP_WIN);
        w_p2_wins   = (bus.score_2 >= LP_WIN);
    end

    // State register, serve counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_WAIT_START;
            r_cnt        <= '0;
            r_p1_point   <= 1'b0;
            r_p2_point   <= 1'b0;
            r_ball_reset <= 1'b1;
            r_serve_dir  <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_p1_point   <= w_p1_point_nxt;
            r_p2_point   <= w_p2_point_nxt;
            r_ball_reset <= w_ball_reset_nxt;
            r_serve_dir  <= w_serve_dir_nxt;
            r_game_over  <= w_game_over_nxt;
            r_winner     <= w_winner_nxt;
        end
    end

    // Next state, serve counter and next output values.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_p1_point_nxt  = 1'b0;
        w_p2_point_nxt  = 1'b0;
        w_serve_dir_nxt = r_serve_dir;
        w_winner_nxt    = r_winner;

        unique case (r_state)
            ST_WAIT_START: begin
                if (bus.start) begin
                    w_state_nxt = ST_PLAY;
                end
            end

            ST_PLAY: begin
                // Left edge wins a tie so the two pulses can never coincide.
                if (bus.frame_tick) begin
                    if (w_left_out) begin
                        w_state_nxt     = ST_SCORED;
                        w_p2_point_nxt  = 1'b1;
                        w_serve_dir_nxt = 1'b0;
                    end else if (w_right_out) begin
                        w_state_nxt     = ST_SCORED;
                        w_p1_point_nxt  = 1'b1;
                        w_serve_dir_nxt = 1'b1;
                    end
                end
            end

            ST_SCORED: begin
                // Frame ticks here are deliberately dropped.
                w_state_nxt = ST_SERVE;
                w_cnt_nxt   = LP_DELAY;
            end

            ST_SERVE: begin
                // Scores have settled by the last serve frame, so decide here.
                if (bus.frame_tick) begin
                    w_cnt_nxt = CNT_W'(r_cnt - CNT_W'(1));
                    if (r_cnt == CNT_W'(1)) begin
                        if (w_p1_wins) begin
                            w_state_nxt  = ST_OVER;
                            w_winner_nxt = 1'b0;
                        end else if (w_p2_wins) begin
                            w_state_nxt  = ST_OVER;
                            w_winner_nxt = 1'b1;
                        end else begin
                            w_state_nxt  = ST_PLAY;
                        end
                    end
                end
            end

            ST_OVER: begin
                w_state_nxt = ST_OVER;
            end

            default: begin
                w_state_nxt = ST_WAIT_START;
                w_cnt_nxt   = '0;
            end
        endcase

        w_ball_reset_nxt = (w_state_nxt != ST_PLAY);
        w_game_over_nxt  = (w_state_nxt == ST_OVER);
    end

    assign bus.p1_point   = r_p1_point;
    assign bus.p2_point   = r_p2_point;
    assign bus.ball_reset = r_ball_reset;
    assign bus.serve_dir  = r_serve_dir;
    assign bus.game_over  = r_game_over;
    assign bus.winner     = r_winner;

endmodule

// File: doc/point_referee.md
# point_referee

Point-detection and serve sequencer for the Pong datapath. It watches the ball's horizontal position once per frame and emits single-cycle `p1_point` / `p2_point` pulses into the score counter. After each point it holds the ball in reset for a programmable serve delay. It declares game over when either score reaches the win threshold. It sits between the ball-motion logic (which supplies `ball_x` and obeys `ball_reset`) and the score counter (which consumes the point pulses and returns `score_1` / `score_2`).

## Interface
Parameters:
- `X_W`, 10: width of `ball_x`.
- `LEFT_LIMIT`, 0: `ball_x <= LEFT_LIMIT` means the ball has left the left edge, so player 2 scores.
- `RIGHT_LIMIT`, 632: `ball_x >= RIGHT_LIMIT` means the ball has left the right edge, so player 1 scores.
- `SERVE_DELAY`, 60: frames the ball is held after a point. Legal range 1..255.
- `WIN_SCORE`, 9: score value that ends the game. Range 1..15.

Ports:
- `clk`  in  1  system clock; the block uses one clock only.
- `rst`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `start`  in  1  begins play. Honoured only in WAIT_START.
- `ball_x`  in  X_W  ball left-edge x position. Sampled only on `frame_tick` in PLAY.
- `score_1`  in  4  player 1 score from the score counter.
- `score_2`  in  4  player 2 score from the score counter.
- `p1_point`  out  1  one-cycle pulse: player 1 scored.
- `p2_point`  out  1  one-cycle pulse: player 2 scored.
- `ball_reset`  out  1  high means the ball logic holds the ball centred and stationary.
- `serve_dir`  out  1  next serve direction: 0 = toward left, 1 = toward right.
- `game_over`  out  1  high once a player reaches `WIN_SCORE`.
- `winner`  out  1  valid when `game_over`: 0 = player 1, 1 = player 2.

## Operation
- **Outputs:** all outputs are registered.
- **States:** WAIT_START, PLAY, SCORED, SERVE, OVER.
- **`ball_reset`:** 0 in PLAY, 1 in every other state.
- **Reset:** on `rst`, the state goes to WAIT_START and `cnt` (8 bits) to 0.
  - Outputs: `p1_point`=0, `p2_point`=0, `ball_reset`=1, `serve_dir`=0, `game_over`=0, `winner`=0.
  - `rst` overrides all other inputs and cancels any pending pulse.
- **WAIT_START:** `start`=1 moves to PLAY.
- **PLAY:** evaluated only when `frame_tick`=1.
  - If `ball_x <= LEFT_LIMIT`: go to SCORED with `p2_point`=1 and `serve_dir`=0 (serve toward the conceding player).
  - Else if `ball_x >= RIGHT_LIMIT`: go to SCORED with `p1_point`=1 and `serve_dir`=1.
  - The left check has priority. The two pulses are never asserted together.
- **SCORED:** lasts exactly one cycle. The pulse drops and the state moves to SERVE with `cnt`=`SERVE_DELAY`. A `frame_tick` in this cycle is ignored.
- **SERVE:** on each `frame_tick`, `cnt` decrements. On the `frame_tick` where `cnt`==1:
  - If `score_1 >= WIN_SCORE`: go to OVER with `winner`=0.
  - Else if `score_2 >= WIN_SCORE`: go to OVER with `winner`=1.
  - Otherwise go to PLAY.
  - `score_*` are stable by then, because the counter updates one cycle after the pulse and `SERVE_DELAY` ≥ 1.
- **OVER:** `game_over`=1 and `ball_reset`=1. The block stays here until `rst`; `start` is ignored. The score counter is cleared by the same `rst`.
- **Ignored inputs:** `start` outside WAIT_START is ignored, and so is `ball_x` without `frame_tick`.

## Timing
- **Point latency:** if `frame_tick` and an out-of-bounds `ball_x` are sampled at edge N, `p?_point`, `ball_reset` and `serve_dir` are high/valid after edge N. The pulse is high for exactly one cycle and drops after edge N+1.
- **Start latency:** `start` sampled at edge M makes `ball_reset` low after edge M.
- **Serve hold:** the hold lasts exactly `SERVE_DELAY` `frame_tick`s counted from SERVE entry. `ball_reset` falls (or `game_over` rises) after the edge that samples the last of them.
- **Pulse spacing:** at most one point per frame. The minimum spacing between pulses is `SERVE_DELAY`+1 frames.

## Test plan
1. Reset, then `start` pulse -> after `rst` all outputs at reset values; one cycle after `start`, `ball_reset`=0.
2. PLAY, `frame_tick` with `ball_x`=0, `SERVE_DELAY`=3 -> `p2_point`=1 for one cycle, `serve_dir`=0, `ball_reset`=1. `ball_reset` returns to 0 right after the 3rd subsequent `frame_tick`.
3. PLAY, `frame_tick` with `ball_x`=632 -> `p1_point`=1 for one cycle, `serve_dir`=1, `p2_point` stays 0.
4. PLAY, `ball_x`=0 with `frame_tick`=0, then `ball_x`=300 with `frame_tick`=1 -> no point pulse, `ball_reset` stays 0.
5. SERVE with `score_1`=9, `WIN_SCORE`=9 at the final `frame_tick` -> `game_over`=1, `winner`=0, `ball_reset`=1. A later `start` has no effect.
6. `rst` asserted during SERVE with `cnt`=2, and separately in the SCORED cycle -> next cycle all outputs at reset values. No further pulse occurs, and the state is WAIT_START.
